gpio_seq: RTL

Table-driven GPIO waveform sequencer placed beside the GPIO controller. It drives pad output-value and pad-direction vectors from a small step table, holding each step for a programmable number of prescaled ticks. Its outputs feed the GPIO pad muxing as an alternate source, so bit-banged protocols and LED patterns run without CPU timing. Configuration arrives over a plain register-side write port from the surrounding APB4 wrapper.

---
 rtl/gpio_seq_pkg.sv | 20 ++
 rtl/gpio_seq_tick.sv | 30 +++
 rtl/register.sv | 20 ++
 rtl/gpio_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/gpio_seq_pkg.sv
// Shared types and default sizing for the GPIO waveform sequencer.
package gpio_seq_pkg;

    localparam int GPIO_NUM_DEF = 32;
    localparam int DEPTH_DEF    = 8;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Step-table entry layout at the default sizing; the top re-declares it per instance.
    typedef struct packed {
        logic [GPIO_NUM_DEF-1:0] out;
        logic [GPIO_NUM_DEF-1:0] dir;
        logic [CNT_W_DEF-1:0]    dur;
    } step_t;

endpackage

// File: rtl/gpio_seq_tick.sv
// Prescaler: counts 0..psc and strobes tick on the wrap cycle; held at zero while clr_i.
module gpio_seq_tick
    import gpio_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] psc_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap   = (cnt_q == psc_i);
    assign tick_o = !clr_i && wrap;
    assign cnt_d  = (clr_i || wrap) ? '0 : cnt_q + 1'b1;

    dffr #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (1'b1),
        .d    (cnt_d),
        .q    (cnt_q)
    );

endmodule

// File: rtl/register.sv
// Enabled D flip-flop with asynchronous active-low clear.
module dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/gpio_seq.sv
// Table-driven GPIO waveform sequencer: steps through {out, dir, dur} entries,
// holding each for (dur+1) prescaled ticks.
module gpio_seq
    import gpio_seq_pkg::*;
#(
    parameter int GPIO_NUM = GPIO_NUM_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                     pclk,
    input  logic                     presetn,
    input  logic                     cfg_we_i,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr_i,
    input  logic [GPIO_NUM-1:0]      cfg_out_i,
    input  logic [GPIO_NUM-1:0]      cfg_dir_i,
    input  logic [CNT_W-1:0]         cfg_dur_i,
    input  logic [CNT_W-1:0]         psc_i,
    input  logic [$clog2(DEPTH)-1:0] last_i,
    input  logic                     loop_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    output logic [GPIO_NUM-1:0]      gpio_out_o,
    output logic [GPIO_NUM-1:0]      gpio_dir_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [$clog2(DEPTH)-1:0] step_o
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [GPIO_NUM-1:0] out;
        logic [GPIO_NUM-1:0] dir;
        logic [CNT_W-1:0]    dur;
    } entry_t;

    localparam int EW = $bits(entry_t);

    state_e              state_q;
    state_e              state_d;
    logic                state_bit_q;
    logic [AW-1:0]       step_q,    step_d;
    logic [CNT_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [CNT_W-1:0]    psc_q,     psc_d;
    logic [AW-1:0]       last_q,    last_d;
    logic                loop_q,    loop_d;
    logic [GPIO_NUM-1:0] out_q,     out_d;
    logic [GPIO_NUM-1:0] dir_q,     dir_d;
    logic                done_q,    done_d;

    entry_t              table_q [DEPTH];
    entry_t              wr_entry;
    entry_t              cur_entry;
    entry_t              nxt_entry;
    logic [AW-1:0]       step_inc;
    logic                tick;
    logic                idle;

    assign state_q  = state_e'(state_bit_q);
    assign idle     = (state_q == ST_IDLE);
    assign wr_entry = '{out: cfg_out_i, dir: cfg_dir_i, dur: cfg_dur_i};
    assign step_inc = step_q + 1'b1;

    // Table entries are registers rather than RAM so reset can clear every entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
            logic entry_we;
            assign entry_we = cfg_we_i && idle && (cfg_addr_i == AW'(gi));
            dffr #(.W(EW)) u_entry (
                .clk  (pclk),
                .rst_n(presetn),
                .en   (entry_we),
                .d    (wr_entry),
                .q    (table_q[gi])
            );
        end
    endgenerate

    gpio_seq_tick #(.CNT_W(CNT_W)) u_tick (
        .clk   (pclk),
        .rst_n (presetn),
        .clr_i (idle),
        .psc_i (psc_q),
        .tick_o(tick)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        dur_cnt_d = dur_cnt_q;
        psc_d     = psc_q;
        last_d    = last_q;
        loop_d    = loop_q;
        out_d     = out_q;
        dir_d     = dir_q;
        done_d    = 1'b0;
        cur_entry = table_q[step_q];
        nxt_entry = table_q[step_inc];
        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    state_d   = ST_RUN;
                    psc_d     = psc_i;
                    last_d    = last_i;
                    loop_d    = loop_i;
                    step_d    = '0;
                    dur_cnt_d = '0;
                    out_d     = table_q[0].out;
                    dir_d     = table_q[0].dir;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (dur_cnt_q == cur_entry.dur) begin
                        dur_cnt_d = '0;
                        if (step_q == last_q) begin
                            if (loop_q) begin
                                step_d = '0;
                                out_d  = table_q[0].out;
                                dir_d  = table_q[0].dir;
                            end else begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            step_d = step_inc;
                            out_d  = nxt_entry.out;
                            dir_d  = nxt_entry.dir;
                        end
                    end else begin
                        dur_cnt_d = dur_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    dffr #(.W(1))        u_state (.clk(pclk), .rst_n(presetn), .en(1'b1), .d(state_d),   .q(state_bit_q));
    dffr #(.W(AW))       u_step  (.clk(pclk), .rst_n(presetn), .en(1'b1), .d(step_d),    .q(step_q));
    dffr #(.W(CNT_W))    u_dur   (.clk(pclk), .rst_n(presetn), .en(1'b1), .d(dur_cnt_d), .q(dur_cnt_q));
    dffr #(.W(CNT_W))    u_psc   (.clk(pclk), .rst_n(presetn), .en(1'b1), .d(psc_d),     .q(psc_q));
    dffr #(.W(AW))       u_last  (.clk(pclk), .rst_n(presetn), .en(1'b1), .d(last_d),    .q(last_q));
    dffr #(.W(1))        u_loop  (.clk(pclk), .rst_n(presetn), .en(1'b1), .d(loop_d),    .q(loop_q));
    dffr #(.W(GPIO_NUM)) u_out   (.clk(pclk), .rst_n(presetn), .en(1'b1), .d(out_d),     .q(out_q));
    dffr #(.W(GPIO_NUM)) u_dir   (.clk(pclk), .rst_n(presetn), .en(1'b1), .d(dir_d),     .q(dir_q));
    dffr #(.W(1))        u_done  (.clk(pclk), .rst_n(presetn), .en(1'b1), .d(done_d),    .q(done_q));

    assign gpio_out_o = out_q;
    assign gpio_dir_o = dir_q;
    assign busy_o     = (state_q == ST_RUN);
    assign done_o     = done_q;
    assign step_o     = step_q;

endmodule
